// File: rtl/ps2_key_scheduler.sv
// PS/2 scan-code parser feeding a press-event FIFO and a held-key bitmap.
// Input bytes are registered once, then decoded into make/break effects on the following edge.
module ps2_key_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       evt_pop,
    output logic [2:0] evt_code,
    output logic       evt_valid,
    output logic [7:0] keys_held,
    output logic       overflow,
    output logic [1:0] parse_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Returns {mapped, index}; bare codes that share a value with an extended key stay unmapped.
    function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
        logic [3:0] res;
        case ({ext, code})
            9'h175:  res = 4'b1000;
            9'h172:  res = 4'b1001;
            9'h16B:  res = 4'b1010;
            9'h174:  res = 4'b1011;
            9'h029:  res = 4'b1100;
            9'h076:  res = 4'b1101;
            9'h05A:  res = 4'b1110;
            9'h02D:  res = 4'b1111;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [7:0]      byte_r;
    logic            byte_valid_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [7:0]      keys_held_r, keys_nxt_s;
    logic            overflow_r;
    logic [2:0]      evt_code_r, head_nxt_s;
    logic            evt_valid_r;
    logic [2:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
    logic [CW-1:0]   count_r, count_nxt_s;
    logic            make_s, brk_s, ext_s;
    logic [3:0]      key_s;
    logic [2:0]      idx_s;
    logic            push_req_s, push_do_s, pop_do_s, full_s, drop_s;

    // Parser next state, make/break classification and prefix timeout.
    always_comb begin
        state_nxt_s = state_r;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        ext_s       = 1'b0;
        if (byte_valid_r) begin
            case (state_r)
                IDLE: begin
                    if (byte_r == 8'hF0) begin
                        state_nxt_s = BRK;
                    end else if (byte_r == 8'hE0) begin
                        state_nxt_s = EXT;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_r == 8'hF0) begin
                        state_nxt_s = EXT_BRK;
                    end else if (byte_r == 8'hE0) begin
                        state_nxt_s = EXT;
                    end else begin
                        make_s      = 1'b1;
                        ext_s       = 1'b1;
                        state_nxt_s = IDLE;
                    end
                end
                BRK: begin
                    brk_s       = 1'b1;
                    state_nxt_s = IDLE;
                end
                EXT_BRK: begin
                    brk_s       = 1'b1;
                    ext_s       = 1'b1;
                    state_nxt_s = IDLE;
                end
                default: state_nxt_s = IDLE;
            endcase
        end else if (state_r != IDLE && tmo_cnt_r == TW'(TIMEOUT - 1)) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Key bitmap update and press-event request.
    always_comb begin
        key_s      = map_key(ext_s, byte_r);
        idx_s      = key_s[2:0];
        keys_nxt_s = keys_held_r;
        push_req_s = 1'b0;
        if (make_s && key_s[3] && !keys_held_r[idx_s]) begin
            keys_nxt_s[idx_s] = 1'b1;
            push_req_s        = 1'b1;
        end else if (brk_s && key_s[3]) begin
            keys_nxt_s[idx_s] = 1'b0;
        end else begin
            keys_nxt_s = keys_held_r;
        end
    end

    // FIFO bookkeeping; a pop frees the slot so a push at full still lands.
    always_comb begin
        full_s    = (count_r == CW'(FIFO_DEPTH));
        pop_do_s  = evt_pop && (count_r != '0);
        push_do_s = push_req_s && (!full_s || pop_do_s);
        drop_s    = push_req_s && full_s && !pop_do_s;
        wr_nxt_s  = push_do_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
        rd_nxt_s  = pop_do_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
        case ({push_do_s, pop_do_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (count_nxt_s == '0) begin
            head_nxt_s = 3'd0;
        end else if (push_do_s && rd_nxt_s == wr_ptr_r) begin
            head_nxt_s = idx_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // All state and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            byte_r       <= 8'd0;
            byte_valid_r <= 1'b0;
            state_r      <= IDLE;
            tmo_cnt_r    <= '0;
            keys_held_r  <= 8'd0;
            overflow_r   <= 1'b0;
            evt_code_r   <= 3'd0;
            evt_valid_r  <= 1'b0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 3'd0;
            end
        end else begin
            byte_r       <= byte_in;
            byte_valid_r <= byte_valid;
            state_r      <= state_nxt_s;
            if (state_nxt_s == IDLE || byte_valid_r) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            keys_held_r <= keys_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_do_s) begin
                mem_r[wr_ptr_r] <= idx_s;
            end
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= count_nxt_s;
            evt_code_r  <= head_nxt_s;
            evt_valid_r <= (count_nxt_s != '0);
        end
    end

    assign parse_state = state_r;
    assign keys_held   = keys_held_r;
    assign overflow    = overflow_r;
    assign evt_code    = evt_code_r;
    assign evt_valid   = evt_valid_r;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed bench for ps2_key_scheduler with hand-computed expectations.
module tb_ps2_key_scheduler;

    logic       CLOCK_50;
    logic       Reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       evt_pop;
    logic [2:0] evt_code;
    logic       evt_valid;
    logic [7:0] keys_held;
    logic       overflow;
    logic [1:0] parse_state;

    int n_checks;
    int n_fail;

    ps2_key_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(20)) dut (
        .CLOCK_50    (CLOCK_50),
        .Reset       (Reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .evt_pop     (evt_pop),
        .evt_code    (evt_code),
        .evt_valid   (evt_valid),
        .keys_held   (keys_held),
        .overflow    (overflow),
        .parse_state (parse_state)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Byte is captured at one edge and applied at the next; returns after both.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge CLOCK_50);
        byte_valid = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic pop_evt();
        @(negedge CLOCK_50);
        evt_pop = 1'b1;
        @(negedge CLOCK_50);
        evt_pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        #2 Reset = 1'b1;
        #10 Reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_state"}, 32'(parse_state), 32'd0);
        check_val({tag, "_keys"},  32'(keys_held),   32'h00);
        check_val({tag, "_valid"}, 32'(evt_valid),   32'd0);
        check_val({tag, "_code"},  32'(evt_code),    32'd0);
        check_val({tag, "_ovf"},   32'(overflow),    32'd0);
    endtask

    logic [2:0] exp_seq [4];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        evt_pop    = 1'b0;
        #1 check_zero("rst");
        #22 Reset = 1'b0;

        // Space make with latency check, then its break.
        @(negedge CLOCK_50);
        byte_in    = 8'h29;
        byte_valid = 1'b1;
        @(negedge CLOCK_50);
        byte_valid = 1'b0;
        check_val("lat_keys_early", 32'(keys_held), 32'h00);
        @(negedge CLOCK_50);
        check_val("space_keys",  32'(keys_held), 32'h10);
        check_val("space_valid", 32'(evt_valid), 32'd1);
        check_val("space_code",  32'(evt_code),  32'd4);
        send_byte(8'hF0);
        check_val("brk_state", 32'(parse_state), 32'd1);
        send_byte(8'h29);
        check_val("space_rel_keys",  32'(keys_held),   32'h00);
        check_val("space_rel_valid", 32'(evt_valid),   32'd1);
        check_val("space_rel_code",  32'(evt_code),    32'd4);
        check_val("space_rel_state", 32'(parse_state), 32'd0);
        pop_evt();
        check_val("pop_empty_valid", 32'(evt_valid), 32'd0);
        check_val("pop_empty_code",  32'(evt_code),  32'd0);
        pop_evt();
        check_val("pop_while_empty", 32'(evt_valid), 32'd0);

        // Extended up, bare 75 unmapped, repeat ignored.
        send_byte(8'hE0);
        check_val("ext_state", 32'(parse_state), 32'd2);
        send_byte(8'h75);
        check_val("up_keys", 32'(keys_held), 32'h01);
        check_val("up_code", 32'(evt_code),  32'd0);
        send_byte(8'h75);
        check_val("bare75_keys", 32'(keys_held), 32'h01);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_rep_keys", 32'(keys_held), 32'h01);
        pop_evt();
        check_val("up_count1", 32'(evt_valid), 32'd0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check_val("extbrk_state", 32'(parse_state), 32'd3);
        send_byte(8'h75);
        check_val("up_rel_keys", 32'(keys_held), 32'h00);
        check_val("up_rel_push", 32'(evt_valid), 32'd0);

        // Five presses into a depth-4 FIFO.
        send_byte(8'h29);
        send_byte(8'h76);
        send_byte(8'h5A);
        send_byte(8'h2D);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("ovf_keys", 32'(keys_held), 32'hF1);
        check_val("ovf_flag", 32'(overflow),  32'd1);
        exp_seq = '{3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("ovf_pop%0d", i), 32'(evt_code), 32'(exp_seq[i]));
            pop_evt();
        end
        check_val("ovf_drained", 32'(evt_valid), 32'd0);
        check_val("ovf_sticky",  32'(overflow),  32'd1);
        do_reset();
        check_zero("rst2");

        // Full FIFO with simultaneous push and pop.
        send_byte(8'h29);
        send_byte(8'h76);
        send_byte(8'h5A);
        send_byte(8'h2D);
        check_val("full_head", 32'(evt_code), 32'd4);
        send_byte(8'hE0);
        @(negedge CLOCK_50);
        byte_in    = 8'h75;
        byte_valid = 1'b1;
        @(negedge CLOCK_50);
        byte_valid = 1'b0;
        evt_pop    = 1'b1;
        @(negedge CLOCK_50);
        evt_pop = 1'b0;
        check_val("pp_ovf",  32'(overflow),  32'd0);
        check_val("pp_keys", 32'(keys_held), 32'hF1);
        exp_seq = '{3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("pp_pop%0d_valid", i), 32'(evt_valid), 32'd1);
            check_val($sformatf("pp_pop%0d_code", i),  32'(evt_code),  32'(exp_seq[i]));
            pop_evt();
        end
        check_val("pp_drained", 32'(evt_valid), 32'd0);
        do_reset();

        // Prefix timeout.
        send_byte(8'hE0);
        repeat (10) @(negedge CLOCK_50);
        check_val("tmo_pending", 32'(parse_state), 32'd2);
        repeat (20) @(negedge CLOCK_50);
        check_val("tmo_idle", 32'(parse_state), 32'd0);
        send_byte(8'h6B);
        check_val("tmo_6b_keys",  32'(keys_held), 32'h00);
        check_val("tmo_6b_valid", 32'(evt_valid), 32'd0);
        send_byte(8'hE0);
        repeat (5) @(negedge CLOCK_50);
        send_byte(8'h6B);
        check_val("left_keys", 32'(keys_held), 32'h04);
        check_val("left_code", 32'(evt_code),  32'd2);
        pop_evt();

        // Reset mid-prefix, with stimulus held during reset.
        send_byte(8'h29);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check_val("pre_rst_state", 32'(parse_state), 32'd3);
        @(negedge CLOCK_50);
        #2 Reset = 1'b1;
        #1 check_zero("async_rst");
        byte_in    = 8'h29;
        byte_valid = 1'b1;
        evt_pop    = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        byte_valid = 1'b0;
        evt_pop    = 1'b0;
        check_zero("held_rst");
        #3 Reset = 1'b0;
        send_byte(8'h74);
        check_zero("post_74");
        send_byte(8'h29);
        check_val("post_rst_space", 32'(keys_held), 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_scheduler.md
PS2_KEY_SCHEDULER -- requirements
Module: ps2_key_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, press-event FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1000000, idle cycles before an unfinished prefix is abandoned (20 ms at 50 MHz).
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port byte_in  input  8  raw PS/2 byte, valid only when byte_valid=1.
REQ-006 SHALL have port byte_valid  input  1  one-cycle strobe per received byte; every byte is presented, including F0/E0.
REQ-007 SHALL have port evt_pop  input  1  consumer (player update logic) removes FIFO head this cycle.
REQ-008 SHALL have port evt_code  output  3  key index at FIFO head; 0 when empty.
REQ-009 SHALL have port evt_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port keys_held  output  8  one bit per mapped key, 1 while held.
REQ-011 SHALL have port overflow  output  1  sticky flag, press event dropped.
REQ-012 SHALL have port parse_state  output  2  current parser state encoding.

Function
REQ-013 SHALL map keys: 0=E0 75 (up), 1=E0 72 (down), 2=E0 6B (left), 3=E0 74 (right), 4=29 (space), 5=76 (Esc), 6=5A (Enter), 7=2D (R); all other codes unmapped, including non-E0 75/72/6B/74.
REQ-014 SHALL implement parser states IDLE=0, BRK=1, EXT=2, EXT_BRK=3, advancing only on byte_valid.
REQ-015 IDLE: F0 -> BRK; E0 -> EXT; any other byte -> make of non-extended code, stay IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make of extended code, -> IDLE.
REQ-017 BRK: any byte -> break of non-extended code, -> IDLE; EXT_BRK: any byte -> break of extended code, -> IDLE.
REQ-018 Make of a mapped key not held SHALL set its keys_held bit and push its index; make of a key already held (typematic repeat) SHALL push nothing.
REQ-019 Break of a mapped key SHALL clear its keys_held bit and push nothing; break of a key not held SHALL be a no-op.
REQ-020 Unmapped makes/breaks SHALL change nothing except parser state.
REQ-021 Latency: byte_valid at edge N -> keys_held, evt_valid, evt_code updated after edge N+1 (one register stage).
REQ-022 FIFO SHALL be first-in first-out; evt_pop with evt_valid=1 removes the head at that edge; evt_pop while empty SHALL be ignored.
REQ-023 Push and pop in the same cycle SHALL both occur, at any occupancy, including full; count unchanged.
REQ-024 Push while full without pop SHALL drop the event, set overflow, leave FIFO contents intact; keys_held still updates.
REQ-025 overflow SHALL stay 1 until Reset.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-027 In BRK, EXT, or EXT_BRK, TIMEOUT consecutive cycles with no byte_valid SHALL return parser to IDLE with no key effect; counter restarts on every byte_valid and is held at 0 in IDLE.

Reset
REQ-028 Reset=1 SHALL immediately, without a clock edge, force parse_state=IDLE, keys_held=0, FIFO empty (evt_valid=0, evt_code=0), overflow=0, timeout counter=0.
REQ-029 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial prefix; first byte after release is parsed from IDLE.
REQ-030 While Reset=1, byte_valid and evt_pop SHALL be ignored.

Verification
REQ-031 Bytes 29, F0, 29 -> after 29: keys_held=0x10, evt_valid=1, evt_code=4; after F0 29: keys_held=0x00, FIFO still holds one event 4.
REQ-032 Bytes E0 75, 75, E0 75 -> E0 75 sets bit0, push index 0; bare 75 unmapped; repeat E0 75 no push; FIFO count=1.
REQ-033 Presses of keys 4,5,6,7,0 (FIFO_DEPTH=4), no pop -> FIFO pops out 4,5,6,7; overflow=1; keys_held=0xF1.
REQ-034 FIFO full, next press and evt_pop in same cycle -> count stays 4, head advances, overflow stays 0.
REQ-035 E0, then 1000000 idle cycles, then 6B -> parse_state back to 0 before 6B; 6B unmapped, keys_held unchanged, no push.
REQ-036 E0, F0, then Reset pulse asynchronous to CLOCK_50, then 74 -> all outputs 0 during reset; 74 afterwards is unmapped non-extended make, no effect.
